// File: rtl/acc_bias_gen.sv
// Three-lane accumulate-and-bias producer for the bound/clip stage: sums a programmable
// number of signed products per lane, adds a latched bias, saturates, and strobes the result.
module acc_bias_gen #(
    parameter int P_BW   = 16,
    parameter int B_BW   = 16,
    parameter int AB_BW  = 21,
    parameter int CNT_BW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CNT_BW-1:0] i_acc_len,
    input  logic [1:0]        i_bound_sel,
    input  logic [B_BW-1:0]   i_bias0,
    input  logic [B_BW-1:0]   i_bias1,
    input  logic [B_BW-1:0]   i_bias2,
    input  logic              i_valid,
    input  logic [P_BW-1:0]   i_prod0,
    input  logic [P_BW-1:0]   i_prod1,
    input  logic [P_BW-1:0]   i_prod2,
    output logic              o_ready,
    output logic              o_busy,
    output logic              bound_en,
    output logic [1:0]        o_bound_sel,
    output logic [AB_BW-1:0]  o_acc_bias0,
    output logic [AB_BW-1:0]  o_acc_bias1,
    output logic [AB_BW-1:0]  o_acc_bias2
);

    // Wide enough for 2^CNT_BW-1 full-scale products plus bias without wrapping.
    localparam int ACC_W = P_BW + CNT_BW + 1;
    localparam int SUM_W = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-AB_BW+1){1'b0}}, {(AB_BW-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-AB_BW+1){1'b1}}, {(AB_BW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_BIAS,
        S_OUT
    } state_t;

    state_t                   state_q;
    logic [CNT_BW-1:0]        len_q;
    logic [CNT_BW-1:0]        cnt_q;
    logic [CNT_BW-1:0]        cnt_d;
    logic [1:0]               sel_q;
    logic [B_BW-1:0]          bias_q      [3];
    logic signed [ACC_W-1:0]  acc_q       [3];
    logic signed [ACC_W-1:0]  prod_ext    [3];
    logic signed [SUM_W-1:0]  sum_d       [3];
    logic [AB_BW-1:0]         acc_bias_d  [3];
    logic [AB_BW-1:0]         acc_bias_q  [3];
    logic                     ready_q;
    logic                     busy_q;
    logic                     bound_en_q;
    logic [1:0]               bound_sel_q;

    function automatic logic [AB_BW-1:0] sat_ab(input logic signed [SUM_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[AB_BW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[AB_BW-1:0];
        end
        return v[AB_BW-1:0];
    endfunction

    assign cnt_d = cnt_q + CNT_BW'(1);

    always_comb begin
        prod_ext[0] = {{(ACC_W-P_BW){i_prod0[P_BW-1]}}, i_prod0};
        prod_ext[1] = {{(ACC_W-P_BW){i_prod1[P_BW-1]}}, i_prod1};
        prod_ext[2] = {{(ACC_W-P_BW){i_prod2[P_BW-1]}}, i_prod2};
        for (int k = 0; k < 3; k++) begin
            sum_d[k] = {acc_q[k][ACC_W-1], acc_q[k]}
                     + {{(SUM_W-B_BW){bias_q[k][B_BW-1]}}, bias_q[k]};
            acc_bias_d[k] = sat_ab(sum_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            bound_en_q  <= 1'b0;
            bound_sel_q <= '0;
            for (int k = 0; k < 3; k++) begin
                bias_q[k]     <= '0;
                acc_q[k]      <= '0;
                acc_bias_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        len_q     <= i_acc_len;
                        sel_q     <= i_bound_sel;
                        bias_q[0] <= i_bias0;
                        bias_q[1] <= i_bias1;
                        bias_q[2] <= i_bias2;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        for (int k = 0; k < 3; k++) begin
                            acc_q[k] <= '0;
                        end
                        // A zero-length job skips accumulation and emits the bias alone.
                        if (i_acc_len == '0) begin
                            state_q <= S_BIAS;
                        end else begin
                            state_q <= S_ACC;
                            ready_q <= 1'b1;
                        end
                    end
                end
                S_ACC: begin
                    if (i_valid) begin
                        cnt_q <= cnt_d;
                        for (int k = 0; k < 3; k++) begin
                            acc_q[k] <= acc_q[k] + prod_ext[k];
                        end
                        if (cnt_d == len_q) begin
                            state_q <= S_BIAS;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_BIAS: begin
                    // Results and select only change here so the clip stage sees them stable.
                    for (int k = 0; k < 3; k++) begin
                        acc_bias_q[k] <= acc_bias_d[k];
                    end
                    bound_sel_q <= sel_q;
                    bound_en_q  <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    bound_en_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready     = ready_q;
    assign o_busy      = busy_q;
    assign bound_en    = bound_en_q;
    assign o_bound_sel = bound_sel_q;
    assign o_acc_bias0 = acc_bias_q[0];
    assign o_acc_bias1 = acc_bias_q[1];
    assign o_acc_bias2 = acc_bias_q[2];

endmodule
